// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - framed bit-serial loader driving one-hot tile config_en/config_data strobes.
// Optional CRC-8 record check enabled by defining CFG_LOADER_CRC_EN.
module config_stream_loader #(
  parameter int         ADDR_W    = 4,
  parameter int         NUM_TILES = 16,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [NUM_TILES-1:0] config_en,
  output logic [DATA_W-1:0]    config_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           words_loaded
);

  localparam int SR_W  = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W = $clog2(SR_W);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SYNC  = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_DATA  = 4'd3;
  localparam logic [3:0] S_LAST  = 4'd4;
  localparam logic [3:0] S_WRITE = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
  localparam logic [3:0] S_ERROR = 4'd7;
`ifdef CFG_LOADER_CRC_EN
  localparam logic [3:0] S_CRC   = 4'd8;
`endif

  logic [3:0]        state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              xfer;
  logic              field_end;
  logic              addr_ok;
  logic              enter_write;

  assign xfer      = bit_valid && bit_ready;
  assign field_end = (cnt == '0);
  assign sr_n      = {sr[SR_W-2:0], bit_in};
  assign addr_ok   = (int'(addr_q) < NUM_TILES);

  assign busy = !(state == S_IDLE || state == S_ERROR);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERROR);

`ifdef CFG_LOADER_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_n;

  // Received CRC bits are fed through the same divider; a correct CRC leaves remainder zero.
  always_comb begin
    crc_n = {crc_q[6:0], 1'b0};
    if (crc_q[7] ^ bit_in) crc_n = crc_n ^ 8'h07;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= '0;
    else if (state == S_SYNC || state == S_WRITE) crc_q <= '0;
    else if (xfer) crc_q <= crc_n;
  end

  assign bit_ready   = (state == S_SYNC) || (state == S_ADDR) || (state == S_DATA) ||
                       (state == S_LAST) || (state == S_CRC);
  assign enter_write = xfer && (state == S_CRC) && field_end && (crc_n == 8'h00);
`else
  assign bit_ready   = (state == S_SYNC) || (state == S_ADDR) || (state == S_DATA) ||
                       (state == S_LAST);
  assign enter_write = xfer && (state == S_LAST);
`endif

  // Strobe and data are registered on WRITE entry so they are visible during the WRITE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      config_en   <= '0;
      config_data <= '0;
    end else begin
      config_en <= '0;
      if (enter_write && addr_ok) begin
        config_en   <= NUM_TILES'(1) << addr_q;
        config_data <= sr[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      sr           <= '0;
      cnt          <= '0;
      addr_q       <= '0;
      last_q       <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (xfer && (state inside {S_SYNC, S_ADDR, S_DATA})) sr <= sr_n;
      if (xfer && !field_end) cnt <= cnt - 1'b1;
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state        <= S_SYNC;
            cnt          <= CNT_W'(7);
            words_loaded <= '0;
          end
        end
        S_SYNC: begin
          if (xfer && field_end) begin
            if (sr_n[7:0] == SYNC_WORD) begin
              state <= S_ADDR;
              cnt   <= CNT_W'(ADDR_W - 1);
            end else begin
              state <= S_ERROR;
            end
          end
        end
        S_ADDR: begin
          if (xfer && field_end) begin
            addr_q <= sr_n[ADDR_W-1:0];
            state  <= S_DATA;
            cnt    <= CNT_W'(DATA_W - 1);
          end
        end
        S_DATA: begin
          if (xfer && field_end) state <= S_LAST;
        end
        S_LAST: begin
          if (xfer) begin
            last_q <= bit_in;
`ifdef CFG_LOADER_CRC_EN
            state  <= S_CRC;
            cnt    <= CNT_W'(7);
`else
            state  <= S_WRITE;
`endif
          end
        end
`ifdef CFG_LOADER_CRC_EN
        S_CRC: begin
          if (xfer && field_end) state <= (crc_n == 8'h00) ? S_WRITE : S_ERROR;
        end
`endif
        S_WRITE: begin
          if (addr_ok) begin
            if (words_loaded != 8'hFF) words_loaded <= words_loaded + 8'd1;
            state <= last_q ? S_DONE : S_ADDR;
            cnt   <= CNT_W'(ADDR_W - 1);
          end else begin
            state <= S_ERROR;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - randomized self-checking bench for config_stream_loader (optionally with CFG_LOADER_CRC_EN).
module tb_config_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [15:0] config_en;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  words_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] obs_en[$];
  logic [31:0] obs_data[$];
  int          done_cnt = 0;
  logic [15:0] exp_en[$];
  logic [31:0] exp_data[$];
  int          obs_base = 0;
  int          done_base = 0;

  always #5 clk = ~clk;

  config_stream_loader dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .config_en(config_en), .config_data(config_data),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always @(negedge clk) begin
    if (config_en != 16'h0) begin
      obs_en.push_back(config_en);
      obs_data.push_back(config_data);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

`ifdef CFG_LOADER_CRC_EN
  // Reference CRC by polynomial long division of msg * x^8 by x^8+x^2+x+1.
  function automatic logic [7:0] crc8_ref(input logic [36:0] msg);
    logic [44:0] r;
    r = {msg, 8'h00};
    for (int i = 44; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction
`endif

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    int waited;
    waited = 0;
    bit_valid = 1'b0;
    repeat (gap) begin
      bit_in = 1'($urandom);
      cycle();
    end
    bit_in    = b;
    bit_valid = 1'b1;
    while (!bit_ready && waited < 40) begin
      cycle();
      waited++;
    end
    check("bit_ready_wait", bit_ready, 1'b1);
    if (bit_ready) cycle();
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int gapmax);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], $urandom_range(0, gapmax));
  endtask

  task automatic send_record(input logic [3:0] a, input logic [31:0] d, input logic l,
                             input int gapmax, input bit bad_crc);
    logic [36:0] msg;
    logic [15:0] oh;
`ifdef CFG_LOADER_CRC_EN
    logic [7:0]  c;
`endif
    msg = {a, d, l};
    send_bits(64'(msg), 37, gapmax);
`ifdef CFG_LOADER_CRC_EN
    c = crc8_ref(msg);
    if (bad_crc) c = c ^ (8'h01 << $urandom_range(0, 7));
    send_bits(64'(c), 8, gapmax);
`endif
    if (bad_crc) begin
      check("crc_err", err, 1'b1);
      check("crc_no_strobe", config_en, 16'h0);
    end else begin
      oh = 16'h0001 << a;
      check("strobe_latency_en", config_en, oh);
      check("strobe_latency_data", config_data, d);
      exp_en.push_back(oh);
      exp_data.push_back(d);
    end
  endtask

  task automatic end_session(input int exp_words, input int exp_done);
    int n;
    for (int i = 0; i < 10 && busy; i++) cycle();
    check("session_idle", busy, 1'b0);
    repeat (2) cycle();
    n = obs_en.size() - obs_base;
    check("strobe_count", n, exp_en.size());
    for (int i = 0; i < exp_en.size() && i < n; i++) begin
      check("strobe_order_en", obs_en[obs_base+i], exp_en[i]);
      check("strobe_order_data", obs_data[obs_base+i], exp_data[i]);
    end
    check("words_loaded", words_loaded, exp_words);
    check("done_pulses", done_cnt - done_base, exp_done);
    obs_base  = obs_en.size();
    done_base = done_cnt;
    exp_en.delete();
    exp_data.delete();
  endtask

  initial begin
    int nrec;
    logic [31:0] d;
    rst = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (3) cycle();
    check("rst_bit_ready", bit_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_config_en", config_en, 16'h0);
    check("rst_config_data", config_data, 32'h0);
    check("rst_words", words_loaded, 8'h0);
    rst = 1'b1;
    cycle();

    // Single record; a start while busy must be ignored.
    pulse_start();
    check("busy_after_start", busy, 1'b1);
    send_bits(64'hA5, 8, 0);
    pulse_start();
    send_record(4'h3, 32'hDEADBEEF, 1'b1, 0, 1'b0);
    end_session(1, 1);

    // Asynchronous reset in the middle of a cycle mid-session.
    pulse_start();
    send_bits(64'hA5, 8, 0);
    send_bits(64'h2, 2, 0);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_bit_ready", bit_ready, 1'b0);
    check("arst_config_data", config_data, 32'h0);
    check("arst_config_en", config_en, 16'h0);
    check("arst_words", words_loaded, 8'h0);
    cycle();
    rst = 1'b1;
    cycle();
    check("idle_bit_ready", bit_ready, 1'b0);

    // Bad sync byte then recovery into a two-record frame with gaps.
    pulse_start();
    send_bits(64'hA4, 8, 1);
    check("sync_err", err, 1'b1);
    check("sync_err_ready", bit_ready, 1'b0);
    check("sync_err_busy", busy, 1'b0);
    pulse_start();
    check("err_cleared", err, 1'b0);
    send_bits(64'hA5, 8, 3);
    send_record(4'h0, 32'h0000_0001, 1'b0, 3, 1'b0);
    send_record(4'hF, 32'hFFFF_0000, 1'b1, 3, 1'b0);
    end_session(2, 1);

    // Reset after 10 DATA bits, then a fresh frame.
    pulse_start();
    send_bits(64'hA5, 8, 1);
    send_bits(64'h9, 4, 1);
    send_bits(64'h2AB, 10, 1);
    #3 rst = 1'b0;
    #1;
    check("abort_config_en", config_en, 16'h0);
    check("abort_busy", busy, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    pulse_start();
    send_bits(64'hA5, 8, 2);
    send_record(4'h7, $urandom, 1'b1, 2, 1'b0);
    end_session(1, 1);

    // Randomized sessions.
    for (int s = 0; s < 4; s++) begin
      nrec = $urandom_range(1, 4);
      pulse_start();
      send_bits(64'hA5, 8, 3);
      for (int r = 0; r < nrec; r++)
        send_record(4'($urandom), $urandom, (r == nrec - 1), 3, 1'b0);
      end_session(nrec, 1);
    end

    // Counter saturation.
    pulse_start();
    send_bits(64'hA5, 8, 0);
    for (int r = 0; r < 260; r++) begin
      d = $urandom;
      send_record(4'($urandom), d, (r == 259), 0, 1'b0);
    end
    end_session((260 > 255) ? 255 : 260, 1);

`ifdef CFG_LOADER_CRC_EN
    pulse_start();
    send_bits(64'hA5, 8, 1);
    send_record(4'h5, $urandom, 1'b0, 1, 1'b0);
    send_record(4'hA, $urandom, 1'b1, 1, 1'b1);
    end_session(1, 0);
    check("crc_err_sticky", err, 1'b1);
    pulse_start();
    check("crc_err_cleared", err, 1'b0);
    send_bits(64'hA5, 8, 1);
    send_record(4'hC, $urandom, 1'b1, 1, 1'b0);
    end_session(1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
